// File: rtl/cpu15_pkg.sv
// cpu15_pkg: shared state encoding, phase constants and counter width for the CPU sequencer
package cpu15_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STEP, ST_HALT} state_t;
    localparam logic [1:0] PH_FT = 2'd0;
    localparam logic [1:0] PH_DC = 2'd1;
    localparam logic [1:0] PH_EX = 2'd2;
    localparam logic [1:0] PH_WB = 2'd3;
    localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/stage_phase.sv
// stage_phase: 2-bit phase counter with clear/advance/hold and registered one-hot strobes
// Ports: CLK, RESET_N (async, active-low), clr (force phase to FT), adv (issue strobe for
// current phase and advance), phase (next phase to issue), en (one-hot strobes FT..WB)
module stage_phase
    import cpu15_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       clr,
    input  logic       adv,
    output logic [1:0] phase,
    output logic [3:0] en
);
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            phase <= PH_FT;
            en    <= '0;
        end else begin
            en    <= (adv && !clr) ? (4'b0001 << phase) : 4'b0000;
            phase <= clr ? PH_FT : adv ? phase + 2'd1 : phase;
        end
    end
endmodule

// File: rtl/stage_seq.sv
// stage_seq: four-stage CPU sequencer with run/stop/step/halt/wait control and retire counter
// Ports: CLK, RESET_N (async, active-low), RUN, STOP, STEP, HALT_REQ, WAIT controls;
// EN_FT/EN_DC/EN_EX/EN_WB one-cycle stage strobes, PHASE (next phase to issue),
// RUNNING, HALTED status, N_INSTR retired-instruction count
module stage_seq
    import cpu15_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             RUN,
    input  logic             STOP,
    input  logic             STEP,
    input  logic             HALT_REQ,
    input  logic             WAIT,
    output logic             EN_FT,
    output logic             EN_DC,
    output logic             EN_EX,
    output logic             EN_WB,
    output logic [1:0]       PHASE,
    output logic             RUNNING,
    output logic             HALTED,
    output logic [CNT_W-1:0] N_INSTR
);
    state_t     state;
    logic       stop_pend, halt_pend;
    logic       active, adv, clr, boundary, halt_go, stop_go;
    logic [1:0] phase;
    logic [3:0] en;

    assign active   = state == ST_RUN || state == ST_STEP;
    assign adv      = active && !WAIT;
    assign boundary = adv && phase == PH_WB;
    assign clr      = (state == ST_IDLE && (RUN || STEP)) || (state == ST_HALT && RUN);
    // Requests sampled on the boundary edge itself take effect at that boundary
    assign halt_go  = halt_pend || HALT_REQ;
    // A single step always ends at its boundary; STOP only counts in RUN
    assign stop_go  = stop_pend || (STOP && state == ST_RUN) || state == ST_STEP;

    stage_phase u_phase (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .clr    (clr),
        .adv    (adv),
        .phase  (phase),
        .en     (en)
    );

    assign {EN_WB, EN_EX, EN_DC, EN_FT} = en;
    assign PHASE = phase;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            stop_pend <= 1'b0;
            halt_pend <= 1'b0;
            RUNNING   <= 1'b0;
            HALTED    <= 1'b0;
            N_INSTR   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (RUN || STEP) begin
                    state   <= RUN ? ST_RUN : ST_STEP;
                    RUNNING <= 1'b1;
                end
                ST_HALT: if (RUN) begin
                    state   <= ST_RUN;
                    RUNNING <= 1'b1;
                    HALTED  <= 1'b0;
                end
                default: if (boundary) begin
                    N_INSTR   <= N_INSTR + CNT_W'(1);
                    stop_pend <= 1'b0;
                    halt_pend <= 1'b0;
                    if (halt_go) begin
                        state   <= ST_HALT;
                        RUNNING <= 1'b0;
                        HALTED  <= 1'b1;
                    end else if (stop_go) begin
                        state   <= ST_IDLE;
                        RUNNING <= 1'b0;
                    end
                end else begin
                    halt_pend <= halt_go;
                    stop_pend <= stop_pend || (STOP && state == ST_RUN);
                end
            endcase
        end
    end
endmodule
